// File: rtl/default_slave.sv
// default_slave: AXI endpoint that answers every unmapped transaction with DECERR.
// Independent write (AW/W/B) and read (AR/R) state machines; no input-to-output paths.
// Optional build macro DEFSLV_BEAT_COUNT_EN: when defined, the write data phase ends on
// the beat whose count equals the latched AWLEN and WLAST is ignored; when undefined,
// the data phase ends on WLAST and no write-beat counter is built.

module default_slave #(
  parameter int unsigned ID_W   = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  // write address
  input  logic [ID_W-1:0]     AWID,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic                AWVALID,
  output logic                AWREADY,
  // write data
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  // write response
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  // read address
  input  logic [ID_W-1:0]     ARID,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic                ARVALID,
  output logic                ARREADY,
  // read data
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic             init_q;
  logic [ID_W-1:0]  bid_q, bid_d;
  logic [ID_W-1:0]  rid_q, rid_d;
  logic [LEN_W-1:0] rlen_q, rlen_d;
  logic [LEN_W-1:0] rcnt_q, rcnt_d;
  logic             w_last_beat;

`ifdef DEFSLV_BEAT_COUNT_EN
  logic [LEN_W-1:0] awlen_q, awlen_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;

  assign w_last_beat = (wcnt_q == awlen_q);

  // Write-beat counter and latched burst length.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awlen_q <= '0;
      wcnt_q  <= '0;
    end else begin
      awlen_q <= awlen_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state for the counter: clear on AW, step on every non-final W beat.
  always_comb begin
    awlen_d = awlen_q;
    wcnt_d  = wcnt_q;
    if (AWVALID && AWREADY) begin
      awlen_d = AWLEN;
      wcnt_d  = '0;
    end else if (WVALID && WREADY && !w_last_beat) begin
      wcnt_d = wcnt_q + LEN_W'(1);
    end
  end

  logic unused_in;
  assign unused_in = ^{WDATA, WSTRB, WLAST};
`else
  assign w_last_beat = WLAST;

  logic unused_in;
  assign unused_in = ^{WDATA, WSTRB, AWLEN};
`endif

  // State and payload registers; reset drops any burst or response in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      init_q    <= 1'b0;
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      bid_q     <= '0;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
    end else begin
      init_q    <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      bid_q     <= bid_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
    end
  end

  // Write FSM next-state: accept address, absorb data, return one DECERR response.
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    unique case (w_state_q)
      WIdle: begin
        if (AWVALID && init_q) begin
          bid_d     = AWID;
          w_state_d = WData;
        end
      end
      WData: begin
        if (WVALID && w_last_beat) w_state_d = WResp;
      end
      WResp: begin
        if (BREADY) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // Read FSM next-state: one zero-data DECERR beat per RREADY cycle.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    unique case (r_state_q)
      RIdle: begin
        if (ARVALID && init_q) begin
          rid_d     = ARID;
          rlen_d    = ARLEN;
          rcnt_d    = '0;
          r_state_d = RData;
        end
      end
      RData: begin
        if (RREADY) begin
          // Compare before increment so the counter never wraps at len == max.
          if (rcnt_q == rlen_q) r_state_d = RIdle;
          else                  rcnt_d = rcnt_q + LEN_W'(1);
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  // Outputs decoded from registered state only; payloads forced to 0 when not valid.
  always_comb begin
    AWREADY = (w_state_q == WIdle) && init_q;
    WREADY  = (w_state_q == WData);
    BVALID  = (w_state_q == WResp);
    BID     = BVALID ? bid_q : '0;
    BRESP   = BVALID ? RespDecErr : 2'b00;
    ARREADY = (r_state_q == RIdle) && init_q;
    RVALID  = (r_state_q == RData);
    RID     = RVALID ? rid_q : '0;
    RDATA   = '0;
    RRESP   = RVALID ? RespDecErr : 2'b00;
    RLAST   = RVALID && (rcnt_q == rlen_q);
  end

endmodule

// File: doc/default_slave.md
# default_slave

AXI slave endpoint that terminates every transaction whose address matches no mapped slave, answering each with a DECERR response. It sits directly downstream of the address decoder. The decoder's default-destination valid drives this block's AWVALID/ARVALID, and this block's handshake and response signals return to the master through the interconnect. Read and write channels run two independent state machines, so one read burst and one write burst can be in flight at the same time.

## Interface
- ID_W, default 8: width of the AXI ID fields on the slave side.
- DATA_W, default 32: data width. Must equal `AXI_DATA_BITS.
- LEN_W, default 4: width of the burst-length fields. Must equal `AXI_LEN_BITS.
- ACLK  in  1  clock. Single clock domain.
- ARESETn  in  1  reset. Asynchronous assert, active-low.
- AWID  in  ID_W  write address ID.
- AWLEN  in  LEN_W  write burst length minus 1.
- AWVALID / AWREADY  in / out  1  write address handshake.
- WDATA  in  DATA_W  ignored. WSTRB  in  DATA_W/8  ignored.
- WLAST  in  1  last write beat.
- WVALID / WREADY  in / out  1  write data handshake.
- BID  out  ID_W  response ID. BRESP  out  2  write response.
- BVALID / BREADY  out / in  1  write response handshake.
- ARID  in  ID_W  read address ID.
- ARLEN  in  LEN_W  read burst length minus 1.
- ARVALID / ARREADY  in / out  1  read address handshake.
- RID  out  ID_W  read ID. RDATA  out  DATA_W  read data. RRESP  out  2  read response. RLAST  out  1  last read beat.
- RVALID / RREADY  out / in  1  read data handshake.

## Operation
- Write FSM states and transitions:
  - W_IDLE: AWREADY=1. An AW handshake latches AWID and AWLEN and moves to W_DATA.
  - W_DATA: WREADY=1. Each W handshake is absorbed and the write-beat counter increments. The handshake with WLAST=1 moves to W_RESP.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=2'b11. The B handshake moves to W_IDLE.
- Read FSM states and transitions:
  - R_IDLE: ARREADY=1. An AR handshake latches ARID and ARLEN, clears the beat counter and moves to R_DATA.
  - R_DATA: RVALID=1, RID=latched ID, RDATA=0, RRESP=2'b11, RLAST=(cnt==len).
    - An R handshake with RLAST=0 increments cnt.
    - An R handshake with RLAST=1 moves to R_IDLE.
- Beat counters are LEN_W bits wide. len=15 gives 16 beats. The compare cnt==len is done before the increment, so the counter never wraps.
- All outputs not named as active in the current state are 0. BRESP, RRESP, RDATA and RLAST are 0 when the matching VALID is low.
- A WVALID that arrives before the AW handshake is stalled (WREADY=0 in W_IDLE). It is accepted once W_DATA is entered.
- AW and AR arriving in the same cycle are both accepted. The two FSMs never interact.
- ARESETn low from any state forces both FSMs to IDLE. Any burst or response in progress is dropped and no response is issued for it.

## Timing
- Reset values: every output is 0, including AWREADY and ARREADY.
- A registered init flag is cleared by reset and set on the first ACLK rising edge after ARESETn deasserts.
  - AWREADY = W_IDLE & init. ARREADY = R_IDLE & init.
  - The ready signals therefore rise one cycle after reset release.
- The ready signals are decoded directly from registered state and the init flag. There are no combinational paths from inputs to outputs.
- Write latency:
  - AW handshake at edge t: WREADY is high from cycle t+1.
  - Last W handshake at edge t': BVALID is high from t'+1.
  - B handshake at edge t'': AWREADY is high from t''+1.
- Read latency:
  - AR handshake at edge t: RVALID is high from t+1.
  - One beat per cycle while RREADY=1. A burst of ARLEN+1 beats with RREADY held high occupies exactly ARLEN+1 cycles.
  - After the final handshake, ARREADY is high the next cycle.
- Once BVALID or RVALID is asserted, that signal and its payload stay stable until the handshake completes.

## Configuration
- DEFSLV_BEAT_COUNT_EN:
  - Defined: the write data phase ends on the handshake where the write-beat counter equals the latched AWLEN. WLAST is ignored.
  - Undefined: the write data phase ends on the WLAST handshake. The write-beat counter is not instantiated.

## Test plan
- Reset release: all outputs are 0 while ARESETn=0. AWREADY=1 and ARREADY=1 exactly one cycle after deassert.
- Read burst with ARID=8'h5A, ARLEN=3, RREADY held at 1: 4 beats on consecutive cycles, each with RID=8'h5A, RDATA=0, RRESP=2'b11. RLAST=1 only on beat 4. ARREADY=1 the following cycle.
- Write with AWID=8'h21, AWLEN=1, 2 W beats (WLAST on the 2nd), BREADY held low for 3 cycles: BVALID held stable with BID=8'h21 and BRESP=2'b11 until the BREADY handshake.
- Read with ARLEN=15 and RREADY toggling 1/0: exactly 16 handshakes, RLAST only on the 16th, and RVALID held stable while RREADY=0.
- Simultaneous AW+AR, with W sent 2 cycles before AW: both addresses accepted in the same cycle. WREADY=0 until the cycle after AW. B and R responses complete independently.
- Reset pulsed mid-read at beat 2 of ARLEN=7: RVALID=0 immediately. ARREADY=1 one cycle after release. No RLAST is ever emitted for that burst.
